// File: rtl/fc_output_collector_pkg.sv
// Shared definitions for the fully-connected output collector: default sizing
// and the collector FSM state encoding.
package fc_output_collector_pkg;

    localparam int N_HIDDEN   = 128;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_COLLECT  = 2'd0,
        ST_PRESTART = 2'd1,
        ST_STREAM   = 2'd2,
        ST_FINISH   = 2'd3
    } fc_state_e;

endpackage : fc_output_collector_pkg

// File: rtl/fc_output_collector_if.sv
// Stream bundle between the fully-connected layer, the collector and the next
// layer; the slave view is the collector itself.
interface fc_output_collector_if
    import fc_output_collector_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_done;
    logic              m_start;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              frame_done;
    logic              busy;
    logic              err_short;
    logic              err_drop;

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_done,
        output m_start,
        output m_data,
        output m_valid,
        output frame_done,
        output busy,
        output err_short,
        output err_drop
    );

    modport master (
        output s_data,
        output s_valid,
        output s_done,
        input  m_start,
        input  m_data,
        input  m_valid,
        input  frame_done,
        input  busy,
        input  err_short,
        input  err_drop
    );

endinterface : fc_output_collector_if

// File: rtl/fc_output_collector_act_buffer.sv
// Activation buffer: one write port, one read port with a registered
// (1-cycle) output. Contents are deliberately left uninitialised.
module fc_output_collector_act_buffer #(
    parameter int DEPTH  = 128,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Storage write and synchronous read
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule : fc_output_collector_act_buffer

// File: rtl/fc_output_collector.sv
// Collects one frame of fully-connected results (with optional ReLU) and
// re-streams it in index order, framed by start and done pulses.
module fc_output_collector
    import fc_output_collector_pkg::*;
#(
    parameter int N_NEURONS = N_HIDDEN,
    parameter int DATA_W    = DATA_W_DEF,
    parameter bit RELU_EN   = 1'b1,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    fc_output_collector_if.slave  bus
);

    localparam int ADDR_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_NEURONS - 1);
    localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N_NEURONS);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO     = CNT_W'(0);

    fc_state_e         state_r;
    fc_state_e         state_nxt_s;
    logic [CNT_W-1:0]  wr_idx_r;
    logic [CNT_W-1:0]  rd_idx_r;
    logic [CNT_W-1:0]  beat_cnt_r;
    logic              complete_s;
    logic              abort_s;
    logic              we_s;
    logic              re_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] rdata_s;

    logic              m_start_r;
    logic [DATA_W-1:0] m_data_r;
    logic              m_valid_r;
    logic              frame_done_r;
    logic              busy_r;
    logic              err_short_r;
    logic              err_drop_r;

    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] y;
        if (RELU_EN && x[DATA_W-1]) begin
            y = {DATA_W{1'b0}};
        end else begin
            y = x;
        end
        return y;
    endfunction

    // A write of the last index completes the frame even if s_done arrives with it
    assign we_s       = (state_r == ST_COLLECT) && bus.s_valid;
    assign complete_s = we_s && (wr_idx_r == LAST_IDX);
    assign abort_s    = (state_r == ST_COLLECT) && bus.s_done && !complete_s
                        && (wr_idx_r != ZERO);
    assign wdata_s    = relu(bus.s_data);
    assign re_s       = (rd_idx_r < N_CNT);

    // rd_idx_r runs one address ahead of the output beat so that m_data can be
    // a resettable register behind the RAM's own output register.
    fc_output_collector_act_buffer #(
        .DEPTH  (N_NEURONS),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_act_buffer (
        .clk   (clk),
        .we    (we_s),
        .waddr (wr_idx_r[ADDR_W-1:0]),
        .wdata (wdata_s),
        .re    (re_s),
        .raddr (rd_idx_r[ADDR_W-1:0]),
        .rdata (rdata_s)
    );

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_COLLECT: begin
                if (complete_s) begin
                    state_nxt_s = ST_PRESTART;
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_PRESTART: state_nxt_s = ST_STREAM;
            ST_STREAM: begin
                if (beat_cnt_r == LAST_IDX) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            ST_FINISH: state_nxt_s = ST_COLLECT;
            default:   state_nxt_s = ST_COLLECT;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_COLLECT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Write index, read-ahead index and beat counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_idx_r   <= ZERO;
            rd_idx_r   <= ZERO;
            beat_cnt_r <= ZERO;
        end else begin
            beat_cnt_r <= (state_r == ST_STREAM) ? beat_cnt_r + ONE : ZERO;
            case (state_r)
                ST_COLLECT: begin
                    rd_idx_r <= complete_s ? ONE : ZERO;
                    if (abort_s) begin
                        wr_idx_r <= ZERO;
                    end else if (we_s) begin
                        wr_idx_r <= wr_idx_r + ONE;
                    end else begin
                        wr_idx_r <= wr_idx_r;
                    end
                end
                ST_PRESTART, ST_STREAM: begin
                    if (rd_idx_r < N_CNT) begin
                        rd_idx_r <= rd_idx_r + ONE;
                    end
                end
                ST_FINISH: begin
                    wr_idx_r <= ZERO;
                    rd_idx_r <= ZERO;
                end
                default: begin
                    wr_idx_r <= ZERO;
                    rd_idx_r <= ZERO;
                end
            endcase
        end
    end

    // Registered outputs, decoded from the upcoming state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_start_r    <= 1'b0;
            m_data_r     <= {DATA_W{1'b0}};
            m_valid_r    <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
            err_short_r  <= 1'b0;
            err_drop_r   <= 1'b0;
        end else begin
            m_start_r    <= (state_nxt_s == ST_PRESTART);
            m_valid_r    <= (state_nxt_s == ST_STREAM);
            m_data_r     <= (state_nxt_s == ST_STREAM) ? rdata_s : {DATA_W{1'b0}};
            frame_done_r <= (state_nxt_s == ST_FINISH);
            busy_r       <= (state_nxt_s != ST_COLLECT);
            err_short_r  <= err_short_r | abort_s;
            err_drop_r   <= err_drop_r | ((state_r != ST_COLLECT) && bus.s_valid);
        end
    end

    assign bus.m_start    = m_start_r;
    assign bus.m_data     = m_data_r;
    assign bus.m_valid    = m_valid_r;
    assign bus.frame_done = frame_done_r;
    assign bus.busy       = busy_r;
    assign bus.err_short  = err_short_r;
    assign bus.err_drop   = err_drop_r;

endmodule : fc_output_collector

// File: tb/tb_fc_output_collector.sv
// Directed bench: two collectors (ReLU on / ReLU off) fed identical frames.
module tb_fc_output_collector;

    localparam int N = 128;
    localparam int NONE = -1;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    fc_output_collector_if #(.DATA_W(16)) bus_r ();
    fc_output_collector_if #(.DATA_W(16)) bus_l ();

    fc_output_collector #(
        .N_NEURONS (N), .DATA_W (16), .RELU_EN (1'b1), .CNT_W (8)
    ) u_dut_relu (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_r)
    );

    fc_output_collector #(
        .N_NEURONS (N), .DATA_W (16), .RELU_EN (1'b0), .CNT_W (8)
    ) u_dut_lin (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic dn);
        bus_r.s_valid = v; bus_r.s_data = d; bus_r.s_done = dn;
        bus_l.s_valid = v; bus_l.s_data = d; bus_l.s_done = dn;
    endtask

    // Feed samples i-64 (i=0..N-1) with 'gap' idle cycles between them, then check the frame.
    task automatic run_frame(input int gap, input bit done_last, input int inject_beat,
                             input int reset_beat);
        logic [15:0] exp_r;
        logic [15:0] exp_l;
        for (int i = 0; i < N; i++) begin
            drive(1'b1, 16'(i - 64), (done_last && i == N - 1));
            step();
            drive(1'b0, 16'h0000, 1'b0);
            if (i < N - 1) begin
                for (int g = 0; g < gap; g++) begin
                    vectors++;
                    if (bus_r.busy !== 1'b0) begin
                        miscompares++;
                        $display("FAIL busy_during_collect: sample %0d got %b, expected 0", i, bus_r.busy);
                    end
                    step();
                end
            end
        end
        vectors++;
        if (bus_r.m_start !== 1'b1 || bus_l.m_start !== 1'b1 || bus_r.m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL m_start_pulse: got start %b/%b valid %b, expected 1/1 0",
                     bus_r.m_start, bus_l.m_start, bus_r.m_valid);
        end
        vectors++;
        if (bus_r.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_prestart: got %b, expected 1", bus_r.busy);
        end
        step();
        for (int k = 0; k < N; k++) begin
            exp_l = 16'(k - 64);
            exp_r = (k < 64) ? 16'h0000 : exp_l;
            if (k == reset_beat) begin
                reset = 1'b0;
                #1;
                vectors++;
                if (bus_r.m_valid !== 1'b0 || bus_r.m_data !== 16'h0000 || bus_r.busy !== 1'b0
                    || bus_r.err_short !== 1'b0 || bus_l.m_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL async_reset: got valid %b data %h busy %b err_short %b, expected 0 0000 0 0",
                             bus_r.m_valid, bus_r.m_data, bus_r.busy, bus_r.err_short);
                end
                return;
            end
            if (k == inject_beat) begin
                drive(1'b1, 16'h7FFF, 1'b0);
            end else begin
                drive(1'b0, 16'h0000, 1'b0);
            end
            vectors++;
            if (bus_r.m_valid !== 1'b1 || bus_r.m_data !== exp_r) begin
                miscompares++;
                $display("FAIL relu_beat: beat %0d got valid %b data %h, expected 1 %h",
                         k, bus_r.m_valid, bus_r.m_data, exp_r);
            end
            vectors++;
            if (bus_l.m_valid !== 1'b1 || bus_l.m_data !== exp_l) begin
                miscompares++;
                $display("FAIL linear_beat: beat %0d got valid %b data %h, expected 1 %h",
                         k, bus_l.m_valid, bus_l.m_data, exp_l);
            end
            step();
        end
        drive(1'b0, 16'h0000, 1'b0);
        vectors++;
        if (bus_r.frame_done !== 1'b1 || bus_l.frame_done !== 1'b1 || bus_r.m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_done_pulse: got done %b/%b valid %b, expected 1/1 0",
                     bus_r.frame_done, bus_l.frame_done, bus_r.m_valid);
        end
        step();
        vectors++;
        if (bus_r.frame_done !== 1'b0 || bus_r.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_collect: got done %b busy %b, expected 0 0",
                     bus_r.frame_done, bus_r.busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 16'h0000, 1'b0);
        step();
        step();
        vectors++;
        if ({bus_r.m_start, bus_r.m_valid, bus_r.frame_done, bus_r.busy, bus_r.err_short,
             bus_r.err_drop} !== 6'b000000 || bus_r.m_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_outputs: got flags %b%b%b%b%b%b data %h, expected 000000 0000",
                     bus_r.m_start, bus_r.m_valid, bus_r.frame_done, bus_r.busy,
                     bus_r.err_short, bus_r.err_drop, bus_r.m_data);
        end
        vectors++;
        if (bus_l.busy !== 1'b0 || bus_l.m_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_linear: got busy %b data %h, expected 0 0000", bus_l.busy, bus_l.m_data);
        end
        #2;
        reset = 1'b1;
        step();
    endtask

    task automatic test_relu_frame();
        run_frame(0, 1'b0, NONE, NONE);
    endtask

    task automatic test_gapped_done_with_last();
        run_frame(2, 1'b1, NONE, NONE);
        vectors++;
        if (bus_r.err_short !== 1'b0) begin
            miscompares++;
            $display("FAIL done_with_last_write: err_short got %b, expected 0", bus_r.err_short);
        end
    endtask

    task automatic test_short_frame();
        drive(1'b0, 16'h0000, 1'b1);
        step();
        drive(1'b0, 16'h0000, 1'b0);
        step();
        vectors++;
        if (bus_r.err_short !== 1'b0) begin
            miscompares++;
            $display("FAIL done_when_empty: err_short got %b, expected 0", bus_r.err_short);
        end
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 16'h1234, 1'b0);
            step();
        end
        drive(1'b0, 16'h0000, 1'b1);
        step();
        drive(1'b0, 16'h0000, 1'b0);
        step();
        vectors++;
        if (bus_r.err_short !== 1'b1 || bus_l.err_short !== 1'b1) begin
            miscompares++;
            $display("FAIL err_short_set: got %b/%b, expected 1/1", bus_r.err_short, bus_l.err_short);
        end
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (bus_r.m_start !== 1'b0 || bus_r.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL short_no_start: cycle %0d got start %b busy %b, expected 0 0",
                         c, bus_r.m_start, bus_r.busy);
            end
            step();
        end
        run_frame(0, 1'b0, NONE, NONE);
        vectors++;
        if (bus_r.err_short !== 1'b1) begin
            miscompares++;
            $display("FAIL err_short_sticky: got %b, expected 1", bus_r.err_short);
        end
    endtask

    task automatic test_drop_during_stream();
        vectors++;
        if (bus_r.err_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL err_drop_clear: got %b, expected 0", bus_r.err_drop);
        end
        run_frame(0, 1'b0, 10, NONE);
        vectors++;
        if (bus_r.err_drop !== 1'b1 || bus_l.err_drop !== 1'b1) begin
            miscompares++;
            $display("FAIL err_drop_set: got %b/%b, expected 1/1", bus_r.err_drop, bus_l.err_drop);
        end
        run_frame(0, 1'b0, NONE, NONE);
    endtask

    task automatic test_reset_mid_stream();
        run_frame(0, 1'b0, NONE, 40);
        drive(1'b0, 16'h0000, 1'b0);
        #2;
        reset = 1'b1;
        step();
        vectors++;
        if (bus_r.err_drop !== 1'b0 || bus_r.m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL after_release: got err_drop %b valid %b, expected 0 0",
                     bus_r.err_drop, bus_r.m_valid);
        end
        run_frame(0, 1'b0, NONE, NONE);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_relu_frame();
        test_gapped_done_with_last();
        test_short_frame();
        test_drop_during_stream();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fc_output_collector
